tmds_video_timing: RTL and testbench

TMDS_VIDEO_TIMING -- requirements
Module: tmds_video_timing

---
 rtl/tmds_video_timing.sv | 174 +++++++++++++++++
 tb/tb_tmds_video_timing.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_video_timing.sv
// Recovers pixel coordinates from a decoded TMDS stream: counts pixels and lines between
// vsync edges, measures the active frame size and reports lock once consecutive frames agree.
module tmds_video_timing #(
  parameter int   CNT_BITS      = 12,
  parameter logic VSYNC_ACTIVE  = 1'b0,
  parameter int   WATCHDOG_BITS = 22
) (
  input  logic                hdmi_clk,
  input  logic                reset,
  input  logic                data_valid,
  input  logic                sync_valid,
  input  logic [1:0]          sync,
  input  logic [7:0]          d0,
  input  logic [7:0]          d1,
  input  logic [7:0]          d2,
  output logic                pixel_valid,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic [CNT_BITS-1:0] x,
  output logic [CNT_BITS-1:0] y,
  output logic                line_start,
  output logic                frame_start,
  output logic [CNT_BITS-1:0] frame_width,
  output logic [CNT_BITS-1:0] frame_height,
  output logic                locked
);

  localparam logic [CNT_BITS-1:0]      CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0]      CNT_ONE = CNT_BITS'(1);
  localparam logic [WATCHDOG_BITS-1:0] WD_MAX  = '1;
  localparam logic [WATCHDOG_BITS-1:0] WD_ONE  = WATCHDOG_BITS'(1);

  typedef enum logic {SEARCH, RUN} state_t;

  state_t                   state, state_nxt;
  logic                     vs_held, dv_prev;
  logic                     first_line, incons, prev_ok;
  logic [CNT_BITS-1:0]      col, row, first_len;
  logic [WATCHDOG_BITS-1:0] wd;

  logic                     vld_p1, ls_p1, fs_p1;
  logic [CNT_BITS-1:0]      x_p1, y_p1;
  logic [7:0]               r_p1, g_p1, b_p1;

  logic                     vs_act, vs_edge, pix, line_end, wd_expire;
  logic                     len_bad, frame_ok, frame_match;
  logic [CNT_BITS-1:0]      row_close, width_close;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // A line end coinciding with the closing vsync edge is folded into the frame measurement.
  always_comb begin
    vs_act      = (sync[1] == VSYNC_ACTIVE);
    vs_edge     = sync_valid && vs_act && !vs_held;
    pix         = data_valid && !sync_valid;
    line_end    = dv_prev && !data_valid;
    wd_expire   = (state == RUN) && (wd == WD_MAX) && !vs_edge;
    row_close   = line_end ? sat_inc(row) : row;
    width_close = '0;
    if (!first_line)
      width_close = first_len;
    else if (line_end)
      width_close = col;
    len_bad     = line_end && !first_line && (col != first_len);
    frame_ok    = !incons && !len_bad && (row_close != '0) && (width_close != '0);
    frame_match = prev_ok && (width_close == frame_width) && (row_close == frame_height);

    state_nxt = state;
    case (state)
      SEARCH:  if (vs_edge) state_nxt = RUN;
      RUN:     if (wd_expire) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      state        <= SEARCH;
      vs_held      <= 1'b0;
      dv_prev      <= 1'b0;
      first_line   <= 1'b1;
      incons       <= 1'b0;
      prev_ok      <= 1'b0;
      col          <= '0;
      row          <= '0;
      first_len    <= '0;
      wd           <= '0;
      vld_p1       <= 1'b0;
      ls_p1        <= 1'b0;
      fs_p1        <= 1'b0;
      x_p1         <= '0;
      y_p1         <= '0;
      r_p1         <= '0;
      g_p1         <= '0;
      b_p1         <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      locked       <= 1'b0;
    end else begin
      state   <= state_nxt;
      dv_prev <= data_valid;
      if (sync_valid)
        vs_held <= vs_act;
      vld_p1 <= 1'b0;
      ls_p1  <= 1'b0;
      fs_p1  <= vs_edge;

      if (state == SEARCH) begin
        if (vs_edge) begin
          col        <= '0;
          row        <= '0;
          first_line <= 1'b1;
          incons     <= 1'b0;
          wd         <= '0;
        end
      end else if (wd_expire) begin
        col        <= '0;
        row        <= '0;
        wd         <= '0;
        first_line <= 1'b1;
        incons     <= 1'b0;
        prev_ok    <= 1'b0;
        locked     <= 1'b0;
      end else begin
        // stage p0 -> p1: register the pixel with its coordinates
        if (pix) begin
          vld_p1 <= 1'b1;
          ls_p1  <= (col == '0);
          x_p1   <= col;
          y_p1   <= row;
          r_p1   <= d2;
          g_p1   <= d1;
          b_p1   <= d0;
          col    <= sat_inc(col);
        end
        if (line_end) begin
          col <= '0;
          row <= sat_inc(row);
          if (first_line) begin
            first_len  <= col;
            first_line <= 1'b0;
          end else if (col != first_len) begin
            incons <= 1'b1;
          end
        end
        if (vs_edge) begin
          frame_width  <= width_close;
          frame_height <= row_close;
          locked       <= frame_ok && frame_match;
          prev_ok      <= frame_ok;
          row          <= '0;
          first_line   <= 1'b1;
          incons       <= 1'b0;
          wd           <= '0;
        end else begin
          wd <= wd + WD_ONE;
        end
      end
    end
  end

  assign pixel_valid = vld_p1;
  assign line_start  = ls_p1;
  assign frame_start = fs_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign r           = r_p1;
  assign g           = g_p1;
  assign b           = b_p1;

endmodule

// File: tb/tb_tmds_video_timing.sv
// Bench for tmds_video_timing: a fixed 4x3 vector table, directed corner sequences and
// randomized frames, all compared against a frame-level reference model.
module tb_tmds_video_timing;
  localparam int         CB     = 4;
  localparam int         WDB    = 8;
  localparam logic       VSA    = 1'b0;
  localparam int         CMAX   = (1 << CB) - 1;
  localparam int         WD_CYC = 1 << WDB;
  localparam logic [1:0] ONW    = {VSA, 1'b0};
  localparam logic [1:0] OFFW   = {~VSA, 1'b0};

  logic          clk = 1'b0, rst = 1'b1, dv = 1'b0, sv = 1'b0;
  logic [1:0]    sy  = OFFW;
  logic [7:0]    i0 = '0, i1 = '0, i2 = '0;
  logic          pixel_valid, line_start, frame_start, locked;
  logic [7:0]    r, g, b;
  logic [CB-1:0] x, y, frame_width, frame_height;

  tmds_video_timing #(.CNT_BITS(CB), .VSYNC_ACTIVE(VSA), .WATCHDOG_BITS(WDB)) dut (
    .hdmi_clk(clk), .reset(rst), .data_valid(dv), .sync_valid(sv), .sync(sy),
    .d0(i0), .d1(i1), .d2(i2), .pixel_valid(pixel_valid), .r(r), .g(g), .b(b),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .frame_width(frame_width), .frame_height(frame_height), .locked(locked)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of line lengths seen since the last vsync edge.
  bit       m_run, m_vsh, m_dvp, m_pok, m_lk, e_pv, e_ls, e_fs;
  int       m_col, m_wd, m_fw, m_fh, e_x, e_y;
  logic [7:0] e_r, e_g, e_b;
  int       m_lines[$];

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_step();
    bit vs_act, vse, pix, lend, cons;
    int w, h;
    if (rst) begin
      m_run = 0; m_vsh = 0; m_dvp = 0; m_pok = 0; m_lk = 0;
      e_pv = 0; e_ls = 0; e_fs = 0; m_col = 0; m_wd = 0; m_fw = 0; m_fh = 0;
      e_x = 0; e_y = 0; e_r = 0; e_g = 0; e_b = 0;
      m_lines.delete();
      return;
    end
    vs_act = (sy[1] == VSA);
    vse    = sv && vs_act && !m_vsh;
    pix    = dv && !sv;
    lend   = m_dvp && !dv;
    e_pv = 0; e_ls = 0; e_fs = vse;
    if (!m_run) begin
      if (vse) begin
        m_run = 1; m_col = 0; m_wd = 0; m_lines.delete();
      end
    end else if (!vse && m_wd == WD_CYC - 1) begin
      m_run = 0; m_lk = 0; m_pok = 0; m_col = 0; m_wd = 0; m_lines.delete();
    end else begin
      if (pix) begin
        e_pv = 1; e_ls = (m_col == 0); e_x = sat(m_col); e_y = sat(m_lines.size());
        e_r = i2; e_g = i1; e_b = i0;
        m_col++;
      end
      if (lend) begin
        m_lines.push_back(m_col);
        m_col = 0;
      end
      if (vse) begin
        h = sat(m_lines.size());
        w = (m_lines.size() > 0) ? sat(m_lines[0]) : 0;
        cons = (h > 0) && (w > 0);
        foreach (m_lines[k]) if (sat(m_lines[k]) != w) cons = 0;
        m_lk  = cons && m_pok && (w == m_fw) && (h == m_fh);
        m_pok = cons; m_fw = w; m_fh = h; m_wd = 0;
        m_lines.delete();
      end else begin
        m_wd++;
      end
    end
    if (sv) m_vsh = vs_act;
    m_dvp = dv;
  endtask

  task automatic compare_model();
    check("model_pv", 32'(pixel_valid), 32'(e_pv));
    check("model_ls", 32'(line_start), 32'(e_ls));
    check("model_fs", 32'(frame_start), 32'(e_fs));
    check("model_lk", 32'(locked), 32'(m_lk));
    check("model_x", 32'(x), e_x);
    check("model_y", 32'(y), e_y);
    check("model_rgb", {8'h0, r, g, b}, {8'h0, e_r, e_g, e_b});
    check("model_fw", 32'(frame_width), m_fw);
    check("model_fh", 32'(frame_height), m_fh);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic set_in(input logic v, input logic s, input logic [1:0] yy,
                        input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    dv = v; sv = s; sy = yy; i0 = c0; i1 = c1; i2 = c2;
  endtask

  task automatic idle(input int n);
    set_in(0, 1, OFFW, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic pixel();
    set_in(1, 0, OFFW, 8'($urandom), 8'($urandom), 8'($urandom));
    tick();
  endtask

  logic cap_fs, cap_lk;
  logic [31:0] cap_fw, cap_fh;

  task automatic vs_pulse();
    set_in(0, 1, ONW, 0, 0, 0);
    tick();
    cap_fs = frame_start; cap_lk = locked;
    cap_fw = 32'(frame_width); cap_fh = 32'(frame_height);
    tick();
    idle(2);
  endtask

  task automatic vs_rand();
    set_in(0, 1, ONW, 0, 0, 0);
    repeat ($urandom_range(1, 3)) tick();
    idle($urandom_range(1, 3));
  endtask

  task automatic frame(input int w, input int h, input int odd_row, input int odd_w,
                       input int nb, input int last_nb, input bit ovl);
    for (int l = 0; l < h; l++) begin
      for (int i = 0; i < ((l == odd_row) ? odd_w : w); i++) begin
        if (ovl && $urandom_range(0, 15) == 0) begin
          set_in(1, 1, OFFW, 8'($urandom), 0, 0);
          tick();
        end
        pixel();
      end
      idle((l == h - 1) ? last_nb : nb);
    end
  endtask

  typedef struct {
    logic dv, sv; logic [1:0] sy; logic [7:0] c;
    logic pv, ls, fs, lk; int ex, ey, fw, fh;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic s, input logic [1:0] yy, input logic [7:0] c,
                     input logic pv, input logic ls, input logic fs, input logic lk,
                     input int ex, input int ey, input int fw, input int fh);
    vec_t t;
    t.dv = v; t.sv = s; t.sy = yy; t.c = c; t.pv = pv; t.ls = ls; t.fs = fs; t.lk = lk;
    t.ex = ex; t.ey = ey; t.fw = fw; t.fh = fh;
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fwe, fhe, w, h, odd;
    logic lke;

    // Two 4x3 frames bracketed by three vsync edges.
    fwe = 0; fhe = 0;
    for (int f = 0; f < 3; f++) begin
      if (f >= 1) begin fwe = 4; fhe = 3; end
      lke = (f == 2);
      add(0, 1, ONW,  0, 0, 0, 1, lke, 0, 0, fwe, fhe);
      add(0, 1, ONW,  0, 0, 0, 0, lke, 0, 0, fwe, fhe);
      add(0, 1, OFFW, 0, 0, 0, 0, lke, 0, 0, fwe, fhe);
      add(0, 1, OFFW, 0, 0, 0, 0, lke, 0, 0, fwe, fhe);
      if (f < 2)
        for (int l = 0; l < 3; l++) begin
          for (int i = 0; i < 4; i++)
            add(1, 0, OFFW, 8'(16 * f + 4 * l + i + 1), 1, (i == 0), 0, lke, i, l, fwe, fhe);
          add(0, 1, OFFW, 0, 0, 0, 0, lke, 0, 0, fwe, fhe);
          add(0, 1, OFFW, 0, 0, 0, 0, lke, 0, 0, fwe, fhe);
        end
    end

    rst = 1;
    set_in(0, 1, OFFW, 0, 0, 0);
    tick(); tick();
    check("reset_pv", 32'(pixel_valid), 0);
    check("reset_lk", 32'(locked), 0);
    check("reset_fw", 32'(frame_width), 0);
    check("reset_fs", 32'(frame_start), 0);
    rst = 0;
    idle(3);

    foreach (tbl[k]) begin
      set_in(tbl[k].dv, tbl[k].sv, tbl[k].sy, tbl[k].c, ~tbl[k].c, tbl[k].c ^ 8'h3c);
      tick();
      check("tbl_pv", 32'(pixel_valid), 32'(tbl[k].pv));
      check("tbl_ls", 32'(line_start), 32'(tbl[k].ls));
      check("tbl_fs", 32'(frame_start), 32'(tbl[k].fs));
      check("tbl_lk", 32'(locked), 32'(tbl[k].lk));
      check("tbl_fw", 32'(frame_width), tbl[k].fw);
      check("tbl_fh", 32'(frame_height), tbl[k].fh);
      if (tbl[k].pv) begin
        check("tbl_x", 32'(x), tbl[k].ex);
        check("tbl_y", 32'(y), tbl[k].ey);
        check("tbl_rgb", {8'h0, r, g, b}, {8'h0, tbl[k].c ^ 8'h3c, ~tbl[k].c, tbl[k].c});
      end
    end

    // One bad line drops lock; two good frames restore it.
    frame(4, 3, 1, 5, 2, 2, 0);
    vs_pulse();
    check("bad_lk", 32'(cap_lk), 0);
    check("bad_fw", cap_fw, 4);
    frame(4, 3, -1, 0, 2, 2, 0);
    vs_pulse();
    check("good1_lk", 32'(cap_lk), 0);
    frame(4, 3, -1, 0, 2, 2, 0);
    vs_pulse();
    check("good2_lk", 32'(cap_lk), 1);
    check("good2_fs", 32'(cap_fs), 1);

    // data_valid together with sync_valid: the word is not a pixel.
    pixel(); pixel();
    set_in(1, 1, OFFW, 8'hAA, 8'hAA, 8'hAA);
    tick();
    check("ovl_pv", 32'(pixel_valid), 0);
    pixel();
    check("ovl_x", 32'(x), 2);
    pixel();
    idle(2);
    frame(4, 2, -1, 0, 2, 2, 0);
    vs_pulse();
    check("ovl_lk", 32'(cap_lk), 1);

    // Watchdog: no vsync edge for 2^WDB cycles.
    idle(200);
    check("wd_hold_lk", 32'(locked), 1);
    idle(100);
    check("wd_lk", 32'(locked), 0);
    check("wd_fw", 32'(frame_width), 4);
    for (int i = 0; i < 10; i++) begin
      pixel();
      check("wd_pv", 32'(pixel_valid), 0);
    end
    idle(2);
    vs_pulse();
    check("wd_fs", 32'(cap_fs), 1);
    pixel();
    check("wd_resync_pv", 32'(pixel_valid), 1);
    check("wd_resync_xy", {28'h0, x, y} & 32'hFF, 0);
    check("wd_resync_ls", 32'(line_start), 1);
    pixel(); pixel(); pixel();
    idle(2);

    // Reset at pixel (2,1).
    vs_pulse();
    frame(4, 1, -1, 0, 2, 2, 0);
    pixel(); pixel();
    check("pre_rst_x", 32'(x), 1);
    rst = 1;
    set_in(1, 0, OFFW, 8'h5A, 8'hA5, 8'hFF);
    tick();
    rst = 0;
    check("rst_pv", 32'(pixel_valid), 0);
    check("rst_xy", {24'h0, x, y}, 0);
    check("rst_rgb", {8'h0, r, g, b}, 0);
    check("rst_flags", {28'h0, line_start, frame_start, locked, 1'b0}, 0);
    check("rst_fwfh", {24'h0, frame_width, frame_height}, 0);
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 2) idle(1); else pixel();
      check("rst_quiet", {30'h0, pixel_valid, frame_start}, 0);
    end
    vs_pulse();
    pixel();
    check("rst_resync_pv", 32'(pixel_valid), 1);
    check("rst_resync_xy", {24'h0, x, y}, 0);
    pixel(); pixel(); pixel();
    idle(2);

    // Saturation with 4-bit counters.
    vs_pulse();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 20; i++) begin
        pixel();
        if (i >= 15) check("sat_x", 32'(x), 15);
      end
      idle(2);
    end
    vs_pulse();
    check("sat_fw", cap_fw, 15);
    check("sat_fh", cap_fh, 2);

    // Randomized frames, occasionally repeated so lock can form, and occasional stalls.
    w = 4; h = 3;
    repeat (40) begin
      vs_rand();
      if ($urandom_range(0, 9) < 3) begin
        w = $urandom_range(1, 20);
        h = $urandom_range(1, 5);
      end
      odd = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, h - 1)) : -1;
      frame(w, h, odd, $urandom_range(1, 20), $urandom_range(1, 3), $urandom_range(0, 2), 1);
      if ($urandom_range(0, 11) == 0) idle(WD_CYC + 10);
    end
    vs_rand();
    idle(5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
